// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, flag indices and the stage-1 -> stage-2 payload
// for the single-precision post-add normalize/round stage.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = 25;
    localparam int BIAS   = 127;
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

    // Bit positions inside the 4-bit flag vector {ovf, unf, inx, zero}
    typedef enum logic [1:0] {
        FLG_ZERO = 2'd0,
        FLG_INX  = 2'd1,
        FLG_UNF  = 2'd2,
        FLG_OVF  = 2'd3
    } flag_idx_e;

    // Normalized beat handed from the normalize stage to the round stage.
    // exp10 is signed and 10 bits wide so +1 / -shl never wrap.
    typedef struct packed {
        logic                    sign;
        logic signed [9:0]       exp10;
        logic [MANT_W-1:0]       mant;
        logic                    g;
        logic                    r;
        logic                    s;
        logic [3:0]              pre_flags;
        logic                    special;
    } norm_payload_t;

endpackage

// File: rtl/fp_norm_round_if.sv
// fp_norm_round_if: input beat and output result channels of the
// normalize/round stage. slave = the stage itself, master = its driver.
interface fp_norm_round_if;
    import fp_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [SIG_W-1:0]   in_sig;
    logic [2:0]         in_grs;
    logic [4:0]         in_shl;
    logic               in_zero;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic [3:0]         out_flags;

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_grs, in_shl, in_zero,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_flags
    );

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_grs, in_shl, in_zero,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fp_round_unit.sv
// fp_round_unit: combinational round-and-pack of a normalized payload.
// FP_NORM_RNE_EN defined   -> round to nearest even, overflow to +-inf.
// FP_NORM_RNE_EN undefined -> truncate, overflow saturates to max finite.
module fp_round_unit
    import fp_pkg::*;
(
    input  norm_payload_t p,
    output logic [31:0]   result,
    output logic [3:0]    flags
);

    logic [MANT_W:0]   mant_sum;
    logic [MANT_W-1:0] mant_r;
    logic signed [9:0] exp_r;
    logic              inexact;
`ifdef FP_NORM_RNE_EN
    logic              round_up;
`endif

    // Round the mantissa, fold a mantissa carry into the exponent, then pack
    always_comb begin
        result   = '0;
        flags    = '0;
        inexact  = p.g | p.r | p.s;
`ifdef FP_NORM_RNE_EN
        round_up = p.g & (p.r | p.s | p.mant[0]);
        mant_sum = {1'b0, p.mant} + {{MANT_W{1'b0}}, round_up};
`else
        mant_sum = {1'b0, p.mant};
`endif
        if (mant_sum[MANT_W]) begin
            mant_r = '0;
            exp_r  = p.exp10 + 10'sd1;
        end else begin
            mant_r = mant_sum[MANT_W-1:0];
            exp_r  = p.exp10;
        end

        if (p.special) begin
            result = {p.sign, EXP_MAX, p.mant};
        end else if (p.pre_flags[FLG_ZERO]) begin
            // exact zero or flush-to-zero: flags were settled by normalize
            result = {p.sign, 31'h0};
            flags  = p.pre_flags;
        end else if (exp_r >= 10'sd255) begin
            flags[FLG_OVF] = 1'b1;
            flags[FLG_INX] = 1'b1;
`ifdef FP_NORM_RNE_EN
            result = {p.sign, EXP_MAX, {MANT_W{1'b0}}};
`else
            result = {p.sign, EXP_MAX - 8'd1, {MANT_W{1'b1}}};
`endif
        end else begin
            result         = {p.sign, exp_r[EXP_W-1:0], mant_r};
            flags[FLG_INX] = inexact;
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: 2-stage post-add normalize (stage 1) and round/pack
// (stage 2) pipeline. Rounding mode selected by FP_NORM_RNE_EN inside
// fp_round_unit.
//
// Handshake: a beat moves on in_valid & in_ready, a result on
// out_valid & out_ready. A stage loads whenever it is empty or the stage
// after it is draining this cycle, so in_ready = !s1_valid | !s2_valid |
// out_ready (forced low during reset); it never depends on in_valid.
// Held stages keep their contents untouched.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp_norm_round_if.slave bus
);

    norm_payload_t     nxt;
    norm_payload_t     s1_q;
    logic              s1_valid;
    logic              s2_valid;
    logic [31:0]       result_q;
    logic [3:0]        flags_q;
    logic [31:0]       round_result;
    logic [3:0]        round_flags;
    logic [26:0]       shl_vec;
    logic              s2_adv;
    logic              s1_adv;

    assign s2_adv       = !s2_valid | bus.out_ready;
    assign s1_adv       = !s1_valid | s2_adv;
    assign bus.in_ready = !rst & s1_adv;

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;

    assign shl_vec = {bus.in_sig[23:0], bus.in_grs} << bus.in_shl;

    // Stage-1 normalize: pick exactly one case in priority order
    always_comb begin
        nxt      = '0;
        nxt.sign = bus.in_sign;
        if (bus.in_exp == EXP_MAX) begin
            nxt.special = 1'b1;
            nxt.exp10   = 10'sd255;
            nxt.mant    = bus.in_sig[MANT_W-1:0];
        end else if (bus.in_zero) begin
            nxt.sign                = 1'b0;
            nxt.pre_flags[FLG_ZERO] = 1'b1;
        end else if (bus.in_sig[24]) begin
            nxt.mant  = bus.in_sig[23:1];
            nxt.g     = bus.in_sig[0];
            nxt.r     = bus.in_grs[2];
            nxt.s     = bus.in_grs[1] | bus.in_grs[0];
            nxt.exp10 = $signed({2'b00, bus.in_exp}) + 10'sd1;
        end else if ({3'b000, bus.in_shl} >= bus.in_exp) begin
            // exponent would reach zero or below: flush, keep the sign
            nxt.pre_flags[FLG_UNF]  = 1'b1;
            nxt.pre_flags[FLG_ZERO] = 1'b1;
            nxt.pre_flags[FLG_INX]  = (|bus.in_sig) | (|bus.in_grs);
        end else begin
            nxt.mant  = shl_vec[25:3];
            nxt.g     = shl_vec[2];
            nxt.r     = shl_vec[1];
            nxt.s     = shl_vec[0];
            nxt.exp10 = $signed({2'b00, bus.in_exp}) - $signed({5'b00000, bus.in_shl});
        end
    end

    fp_round_unit u_round (
        .p      (s1_q),
        .result (round_result),
        .flags  (round_flags)
    );

    // Stage-1 register: load a new beat whenever the stage can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= nxt;
            end
        end
    end

    // Stage-2 register: capture the rounded result, hold it while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_q <= round_result;
                flags_q  <= round_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: directed test-plan vectors, backpressure, mid-stream
// reset and randomized traffic against an arithmetic reference model.
module tb_fp_norm_round;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_norm_round_if bus ();

    fp_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_count = 0;
    logic [35:0] exp_q[$];

`ifdef FP_NORM_RNE_EN
    localparam logic [31:0] RND_RES  = 32'h3F800002;
    localparam logic [31:0] RCY_RES  = 32'h40000000;
    localparam logic [31:0] OVF_RES  = 32'h7F800000;
`else
    localparam logic [31:0] RND_RES  = 32'h3F800001;
    localparam logic [31:0] RCY_RES  = 32'h3FFFFFFF;
    localparam logic [31:0] OVF_RES  = 32'h7F7FFFFF;
`endif

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference: value-level normalize/round; returns {flags, result}
    function automatic logic [35:0] ref_model(input logic sign, input logic [7:0] e,
                                              input logic [24:0] sig, input logic [2:0] grs,
                                              input logic [4:0] shl, input logic zero);
        longint full, n, m;
        int     ex, rest;
        bit     inx;
        full = longint'({sig, grs});
        if (e == 8'hFF) return {4'b0000, sign, 8'hFF, sig[22:0]};
        if (zero) return {4'b0001, 32'h0};
        if (sig[24]) begin
            n  = (full >> 1) | (full & 1);
            ex = int'(e) + 1;
        end else if (int'(e) <= int'(shl)) begin
            inx = (full != 0);
            return {1'b0, 1'b1, inx, 1'b1, sign, 31'h0};
        end else begin
            n  = (full << shl) & ((longint'(1) << 27) - 1);
            ex = int'(e) - int'(shl);
        end
        m    = (n >> 3) & 64'h7FFFFF;
        rest = int'(n & 7);
        inx  = (rest != 0);
`ifdef FP_NORM_RNE_EN
        if (rest > 4 || (rest == 4 && m[0])) m = m + 1;
        if (m == 64'h800000) begin
            m  = 0;
            ex = ex + 1;
        end
`endif
        if (ex >= 255) begin
`ifdef FP_NORM_RNE_EN
            return {4'b1010, sign, 31'h7F800000};
`else
            return {4'b1010, sign, 31'h7F7FFFFF};
`endif
        end
        return {2'b00, inx, 1'b0, sign, 8'(ex), 23'(m)};
    endfunction

    // Scoreboard: push on accept, pop and compare on result transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.in_sign, bus.in_exp, bus.in_sig,
                                          bus.in_grs, bus.in_shl, bus.in_zero));
                acc_count++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("queue_underflow", 36'(exp_q.size()), 36'd1);
                else check("result", {bus.out_flags, bus.out_result}, exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic sign, input logic [7:0] e, input logic [24:0] sig,
                             input logic [2:0] grs, input logic [4:0] shl, input logic zero);
        int wait_cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_sign  = sign;
        bus.in_exp   = e;
        bus.in_sig   = sig;
        bus.in_grs   = grs;
        bus.in_shl   = shl;
        bus.in_zero  = zero;
        @(negedge clk);
        while (!bus.in_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 36'(bus.in_ready), 36'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic sign, input logic [7:0] e,
                            input logic [24:0] sig, input logic [2:0] grs, input logic [4:0] shl,
                            input logic zero, input logic [31:0] er, input logic [3:0] ef);
        int w = 0;
        send_beat(sign, e, sig, grs, shl, zero);
        @(negedge clk);
        while (!bus.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check(tag, {bus.out_flags, bus.out_result}, {ef, er});
        @(posedge clk);
        #1;
    endtask

    task automatic send_random();
        logic        sign = 1'($urandom);
        logic [7:0]  e;
        logic [24:0] sig  = 25'($urandom);
        logic [2:0]  grs  = 3'($urandom);
        logic [4:0]  shl  = 5'($urandom);
        logic        zero = 1'b0;
        case ($urandom_range(0, 9))
            0:       e = 8'hFF;
            1:       e = 8'hFE;
            2:       e = 8'($urandom_range(0, 6));
            default: e = 8'($urandom_range(1, 254));
        endcase
        if ($urandom_range(0, 1) == 1) sig[24] = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            shl = 5'd0;
            for (int i = 23; i >= 0; i--) begin
                if (sig[i]) begin
                    shl = 5'(23 - i);
                    break;
                end
            end
        end
        if ($urandom_range(0, 15) == 0) begin
            zero = 1'b1;
            sig  = '0;
            grs  = '0;
        end
        send_beat(sign, e, sig, grs, shl, zero);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 36'(exp_q.size()), 36'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          base;
        bit          rand_done;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_sig    = '0;
        bus.in_grs    = '0;
        bus.in_shl    = '0;
        bus.in_zero   = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        #2;
        check("rst_in_ready",  36'(bus.in_ready),  36'd0);
        check("rst_out_valid", 36'(bus.out_valid), 36'd0);
        check("rst_out_data",  {bus.out_flags, bus.out_result}, 36'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 36'(bus.in_ready), 36'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // test-plan vectors
        directed("carry",     1'b0, 8'h80, 25'h1800000, 3'b000, 5'd0, 1'b0, 32'h40C00000, 4'b0000);
        directed("left_shift",1'b0, 8'h85, 25'h0200000, 3'b000, 5'd2, 1'b0, 32'h41800000, 4'b0000);
        directed("zero",      1'b1, 8'h40, 25'h0000000, 3'b000, 5'd0, 1'b1, 32'h00000000, 4'b0001);
        directed("underflow", 1'b1, 8'h02, 25'h0000100, 3'b000, 5'd5, 1'b0, 32'h80000000, 4'b0111);
        directed("round",     1'b0, 8'h7F, 25'h0800001, 3'b100, 5'd0, 1'b0, RND_RES,      4'b0010);
        directed("round_cy",  1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 5'd0, 1'b0, RCY_RES,      4'b0010);
        directed("overflow",  1'b0, 8'hFE, 25'h1000000, 3'b000, 5'd0, 1'b0, OVF_RES,      4'b1010);
        directed("special",   1'b1, 8'hFF, 25'h0400001, 3'b111, 5'd0, 1'b0, 32'hFFC00001, 4'b0000);

        // backpressure: 5 back-to-back beats, output stalled
        bus.out_ready = 1'b0;
        base = acc_count;
        fork
            begin
                for (int i = 0; i < 5; i++) send_random();
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready",  36'(bus.in_ready), 36'd0);
                check("bp_accepts",   36'(acc_count - base), 36'd2);
                check("bp_out_valid", 36'(bus.out_valid), 36'd1);
                held = bus.out_result;
                @(negedge clk);
                check("bp_hold", 36'(bus.out_result), 36'(held));
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // randomized traffic with random output stalls
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_random();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // asynchronous reset with beats in flight
        send_random();
        send_random();
        check("pre_rst_out_valid", 36'(bus.out_valid), 36'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 36'(bus.out_valid), 36'd0);
        check("mid_rst_in_ready",  36'(bus.in_ready),  36'd0);
        check("mid_rst_out_data",  {bus.out_flags, bus.out_result}, 36'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rerelease_in_ready", 36'(bus.in_ready), 36'd1);
        @(posedge clk);
        #1;
        directed("after_rst", 1'b0, 8'h80, 25'h1800000, 3'b000, 5'd0, 1'b0, 32'h40C00000, 4'b0000);
        for (int i = 0; i < 20; i++) send_random();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Post-add normalization and rounding stage of the IEEE-754 single-precision adder/subtractor. It consumes the raw 25-bit significand sum, the leading-one shift count and the zero flag produced by the leading-one detector, together with the pre-normalization exponent, sign and guard/round/sticky bits. It normalizes, rounds and packs the final 32-bit result. The block is a 2-stage valid/ready pipeline sitting between the adder datapath and the result register/writeback.

## Interface
- No parameters; widths come from `fp_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_sign` in 1: result sign.
- `in_exp` in 8: biased exponent before normalization.
- `in_sig` in 25: significand sum. Bit 24 is the carry-out, bit 23 is the hidden-bit position.
- `in_grs` in 3: guard, round, sticky (bit 2 = guard).
- `in_shl` in 5: left-shift count from the leading-one detector.
- `in_zero` in 1: sum is exactly zero.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out 32: packed {sign, exp[7:0], mant[22:0]}.
- `out_flags` out 4: {overflow, underflow, inexact, zero}.

## Operation
- A beat transfers on `in_valid & in_ready`. A result transfers on `out_valid & out_ready`.
- Stage 1 (normalize) selects exactly one case, in this priority order:
  - `in_exp == 8'hFF`: special pass-through. Result is {sign, FF, in_sig[22:0]}, no rounding, flags 0.
  - `in_zero`: result 0x00000000 (+0), zero flag set.
  - `in_sig[24]` set: shift right 1. mant = sig[23:1], g = sig[0], r = grs[2], s = grs[1] | grs[0]. exp + 1.
  - Otherwise, if `in_exp <= in_shl`: flush to ±0 (sign kept). Set underflow and zero flags. Set inexact if any sig/grs bit is nonzero.
  - Otherwise: the 27-bit vector {sig[23:0], grs} shifts left by `in_shl` with zero fill. mant = v[25:3], g/r/s = v[2:0]. exp − shl.
- Internal exponent arithmetic is 10-bit signed, so it never wraps.
- Stage 2 (round, pack):
  - inexact = g | r | s.
  - RNE round-up condition: g & (r | s | mant[0]).
  - If rounding carries out of mant, mant becomes 0 and exp + 1.
  - If exp ≥ 255: overflow + inexact. Result is ±inf 0x7F800000 | sign<<31.

## Timing
- Latency: 2 cycles from input acceptance to `out_valid`. Throughput: 1 beat per cycle.
- `in_ready = !s1_valid | !s2_valid | out_ready`. It is combinational and has no combinational path from `in_valid`.
- With `out_ready` low and both stages full, `in_ready` drops. Held stages keep their data stable and no beat is lost or reordered.
- Simultaneous output drain and input accept in the same cycle is a full-rate transfer.
- Reset values:
  - `out_valid` = 0, `out_result` = 0, `out_flags` = 0.
  - Both stage-valid bits = 0.
  - `in_ready` is held 0 while `rst` is high and is 1 the first cycle after release.
- Reset mid-operation discards all in-flight beats immediately (asynchronous).
- `out_result` and `out_flags` are registered and hold while `out_valid & !out_ready`.

## Configuration
- Macro: `FP_NORM_RNE_EN`.
- Defined: round-to-nearest-even as above.
- Undefined: truncation (round toward zero).
  - The round-up logic is removed.
  - inexact is still reported.
  - Overflow saturates to max finite ±0x7F7FFFFF instead of ±inf.

## Structure
- `fp_pkg` holds:
  - Constants: `EXP_W` = 8, `MANT_W` = 23, `SIG_W` = 25, `EXP_MAX` = 8'hFF, `BIAS` = 127.
  - A flag-index typedef (`FLG_OVF`, `FLG_UNF`, `FLG_INX`, `FLG_ZERO`).
  - A packed struct for the stage-1 → stage-2 payload (sign, exp10, mant, g, r, s, pre-flags, special).
- One sub-module, `fp_round_unit`: combinational round/pack for stage 2. It is the only place `FP_NORM_RNE_EN` is tested.

## Test plan
- Carry case: sig = 0x1800000, exp = 0x80, grs = 0 → 0x40C00000, flags 0.
- Left shift: sig = 0x0200000, shl = 2, exp = 0x85 → 0x41800000.
- Zero: in_zero = 1 → 0x00000000, flags = 4'b0001. Underflow: exp = 0x02, shl = 5, sig nonzero → ±0, flags = 4'b0101 or 4'b0111.
- Rounding: sig = 0x0800001, grs = 3'b100, exp = 0x7F.
  - RNE: 0x3F800002, inexact set.
  - Without macro: 0x3F800001.
- Overflow: sig = 0x1000000, exp = 0xFE.
  - RNE: 0x7F800000, flags = 4'b1010.
  - Without macro: 0x7F7FFFFF.
- Backpressure: 5 back-to-back beats with `out_ready` low for 3 cycles.
  - `in_ready` drops after 2 accepts.
  - All 5 results emerge in order, unchanged.
  - Assert `rst` mid-stream: `out_valid` = 0 immediately.
